// File: rtl/sya_bank_ctrl.sv
// Sequencer for one systolic PE bank: streams K act/wgt beats per output tile,
// marks tile boundaries with acc-reset, flushes the last tile and flags valid out_fm rows.
module sya_bank_ctrl #(
   parameter int NUM_ROW   = 16,
   parameter int NUM_COL   = 16,
   parameter int ACT_WIDTH = 8,
   parameter int WGT_WIDTH = 8,
   parameter int QNT_WIDTH = 20,
   parameter int CNT_WIDTH = 16,
   parameter int DRAIN_LAT = 18
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           cfg_num_k,
   input  logic [CNT_WIDTH-1:0]           cfg_num_tile,
   input  logic [QNT_WIDTH-1:0]           cfg_scale,
   input  logic [ACT_WIDTH-1:0]           cfg_shift,
   input  logic [ACT_WIDTH-1:0]           cfg_zp,
   input  logic                           act_vld,
   output logic                           act_rdy,
   input  logic [ACT_WIDTH*NUM_ROW-1:0]   act_data,
   input  logic                           wgt_vld,
   output logic                           wgt_rdy,
   input  logic [WGT_WIDTH*NUM_COL-1:0]   wgt_data,
   input  logic                           fm_rdy,
   output logic                           bank_vld,
   output logic                           bank_rdy,
   output logic                           bank_acc_reset,
   output logic [ACT_WIDTH*NUM_ROW-1:0]   bank_act,
   output logic [WGT_WIDTH*NUM_COL-1:0]   bank_wgt,
   output logic [QNT_WIDTH-1:0]           quant_scale,
   output logic [ACT_WIDTH-1:0]           quant_shift,
   output logic [ACT_WIDTH-1:0]           quant_zero_point,
   output logic [NUM_ROW-1:0]             fm_row_vld,
   output logic                           busy,
   output logic                           done
);
   localparam int AW       = ACT_WIDTH * NUM_ROW;
   localparam int WW       = WGT_WIDTH * NUM_COL;
   localparam int PIPE_LEN = DRAIN_LAT + NUM_ROW - 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] num_k_q, num_k_d;
   logic [CNT_WIDTH-1:0] num_tile_q, num_tile_d;
   logic [CNT_WIDTH-1:0] k_cnt_q, k_cnt_d;
   logic [CNT_WIDTH-1:0] tile_cnt_q, tile_cnt_d;
   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic [PIPE_LEN-1:0]  pipe_q, pipe_d;
   logic                 bank_vld_q, bank_vld_d;
   logic                 bank_acc_reset_q, bank_acc_reset_d;
   logic                 bank_close_q, bank_close_d;
   logic                 done_q, done_d;
   logic [AW-1:0]        bank_act_q, bank_act_d;
   logic [WW-1:0]        bank_wgt_q, bank_wgt_d;
   logic [QNT_WIDTH-1:0] quant_scale_q, quant_scale_d;
   logic [ACT_WIDTH-1:0] quant_shift_q, quant_shift_d;
   logic [ACT_WIDTH-1:0] quant_zp_q, quant_zp_d;
   logic                 adv;
   logic                 fire;
   logic                 row_last;

   // Handshake: a buffer beat transfers in a cycle where its vld and rdy are both high;
   // rdy is only raised when both buffers offer a beat and the fm sink lets the bank advance.
   assign adv      = fm_rdy;
   assign fire     = (state_q == S_FEED) & act_vld & wgt_vld & adv & ~rst;
   assign row_last = pipe_q[PIPE_LEN-1] & adv;

   assign act_rdy          = fire;
   assign wgt_rdy          = fire;
   assign bank_rdy         = fm_rdy;
   assign bank_vld         = bank_vld_q;
   assign bank_acc_reset   = bank_acc_reset_q;
   assign bank_act         = bank_act_q;
   assign bank_wgt         = bank_wgt_q;
   assign quant_scale      = quant_scale_q;
   assign quant_shift      = quant_shift_q;
   assign quant_zero_point = quant_zp_q;
   assign fm_row_vld       = pipe_q[PIPE_LEN-1 -: NUM_ROW] & {NUM_ROW{adv}};
   assign busy             = (state_q != S_IDLE);
   assign done             = done_q;

   always_comb begin
      state_d          = state_q;
      num_k_d          = num_k_q;
      num_tile_d       = num_tile_q;
      k_cnt_d          = k_cnt_q;
      tile_cnt_d       = tile_cnt_q;
      pipe_d           = pipe_q;
      bank_vld_d       = bank_vld_q;
      bank_acc_reset_d = bank_acc_reset_q;
      bank_close_d     = bank_close_q;
      bank_act_d       = bank_act_q;
      bank_wgt_d       = bank_wgt_q;
      quant_scale_d    = quant_scale_q;
      quant_shift_d    = quant_shift_q;
      quant_zp_d       = quant_zp_q;
      done_d           = 1'b0;
      out_cnt_d        = row_last ? out_cnt_q + CNT_ONE : out_cnt_q;

      // The pipe samples the beat currently at the bank input, so a closing beat
      // reaches tap DRAIN_LAT-1+r exactly DRAIN_LAT+r advancing cycles after it shows.
      if (adv) begin
         pipe_d           = {pipe_q[PIPE_LEN-2:0], bank_close_q};
         bank_vld_d       = 1'b0;
         bank_acc_reset_d = 1'b0;
         bank_close_d     = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_k_d       = cfg_num_k;
               num_tile_d    = cfg_num_tile;
               quant_scale_d = cfg_scale;
               quant_shift_d = cfg_shift;
               quant_zp_d    = cfg_zp;
               k_cnt_d       = '0;
               tile_cnt_d    = '0;
               out_cnt_d     = '0;
               if (cfg_num_k == '0 || cfg_num_tile == '0) done_d = 1'b1;
               else state_d = S_FEED;
            end
         end
         S_FEED: begin
            if (fire) begin
               bank_vld_d       = 1'b1;
               bank_act_d       = act_data;
               bank_wgt_d       = wgt_data;
               bank_acc_reset_d = (k_cnt_q == '0);
               bank_close_d     = (k_cnt_q == '0) && (tile_cnt_q != '0);
               if (k_cnt_q == num_k_q - CNT_ONE) begin
                  k_cnt_d    = '0;
                  tile_cnt_d = tile_cnt_q + CNT_ONE;
                  if (tile_cnt_q == num_tile_q - CNT_ONE) state_d = S_FLUSH;
               end else begin
                  k_cnt_d = k_cnt_q + CNT_ONE;
               end
            end
         end
         S_FLUSH: begin
            if (adv) begin
               bank_acc_reset_d = 1'b1;
               bank_close_d     = 1'b1;
               state_d          = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (row_last && out_cnt_d == num_tile_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         num_k_q          <= '0;
         num_tile_q       <= '0;
         k_cnt_q          <= '0;
         tile_cnt_q       <= '0;
         out_cnt_q        <= '0;
         pipe_q           <= '0;
         bank_vld_q       <= 1'b0;
         bank_acc_reset_q <= 1'b0;
         bank_close_q     <= 1'b0;
         bank_act_q       <= '0;
         bank_wgt_q       <= '0;
         quant_scale_q    <= '0;
         quant_shift_q    <= '0;
         quant_zp_q       <= '0;
         done_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         num_k_q          <= num_k_d;
         num_tile_q       <= num_tile_d;
         k_cnt_q          <= k_cnt_d;
         tile_cnt_q       <= tile_cnt_d;
         out_cnt_q        <= out_cnt_d;
         pipe_q           <= pipe_d;
         bank_vld_q       <= bank_vld_d;
         bank_acc_reset_q <= bank_acc_reset_d;
         bank_close_q     <= bank_close_d;
         bank_act_q       <= bank_act_d;
         bank_wgt_q       <= bank_wgt_d;
         quant_scale_q    <= quant_scale_d;
         quant_shift_q    <= quant_shift_d;
         quant_zp_q       <= quant_zp_d;
         done_q           <= done_d;
      end
   end
endmodule

// File: tb/tb_sya_bank_ctrl.sv
// Directed bench for sya_bank_ctrl: beat scoreboard, advancing-cycle row model
// for fm_row_vld/done, and absolute job-length checks.
module tb_sya_bank_ctrl;
   localparam int NUM_ROW   = 16;
   localparam int NUM_COL   = 16;
   localparam int ACT_WIDTH = 8;
   localparam int WGT_WIDTH = 8;
   localparam int QNT_WIDTH = 20;
   localparam int CNT_WIDTH = 16;
   localparam int DRAIN_LAT = 18;
   localparam int AW = ACT_WIDTH * NUM_ROW;
   localparam int WW = WGT_WIDTH * NUM_COL;
   localparam int EW = AW + WW + 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [CNT_WIDTH-1:0] cfg_num_k = '0;
   logic [CNT_WIDTH-1:0] cfg_num_tile = '0;
   logic [QNT_WIDTH-1:0] cfg_scale = '0;
   logic [ACT_WIDTH-1:0] cfg_shift = '0;
   logic [ACT_WIDTH-1:0] cfg_zp = '0;
   logic                 act_vld = 1'b0;
   logic                 act_rdy;
   logic [AW-1:0]        act_data = '0;
   logic                 wgt_vld = 1'b0;
   logic                 wgt_rdy;
   logic [WW-1:0]        wgt_data = '0;
   logic                 fm_rdy = 1'b1;
   logic                 bank_vld, bank_rdy, bank_acc_reset;
   logic [AW-1:0]        bank_act;
   logic [WW-1:0]        bank_wgt;
   logic [QNT_WIDTH-1:0] quant_scale;
   logic [ACT_WIDTH-1:0] quant_shift, quant_zero_point;
   logic [NUM_ROW-1:0]   fm_row_vld;
   logic                 busy, done;

   sya_bank_ctrl #(
      .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .ACT_WIDTH(ACT_WIDTH), .WGT_WIDTH(WGT_WIDTH),
      .QNT_WIDTH(QNT_WIDTH), .CNT_WIDTH(CNT_WIDTH), .DRAIN_LAT(DRAIN_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_k(cfg_num_k), .cfg_num_tile(cfg_num_tile),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
      .act_vld(act_vld), .act_rdy(act_rdy), .act_data(act_data),
      .wgt_vld(wgt_vld), .wgt_rdy(wgt_rdy), .wgt_data(wgt_data),
      .fm_rdy(fm_rdy), .bank_vld(bank_vld), .bank_rdy(bank_rdy),
      .bank_acc_reset(bank_acc_reset), .bank_act(bank_act), .bank_wgt(bank_wgt),
      .quant_scale(quant_scale), .quant_shift(quant_shift),
      .quant_zero_point(quant_zero_point), .fm_row_vld(fm_row_vld),
      .busy(busy), .done(done)
   );

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench did not finish");
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [EW+1:0] obs, input logic [EW+1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard state
   logic [EW-1:0] exp_q[$];   // {closing, acc_reset, act, wgt}
   int            stamp_q[$]; // advancing-cycle stamps of closing beats
   int            job_k = 1, job_tiles = 1;
   bit            acc_start = 0, zero_start = 0;
   int            beat_idx = 1 << 30;
   int            pop_n = 0, fire_n = 0, row15_n = 0, adv_n = 0;
   bit            prev_adv = 0, flush_pend = 0, flush_next = 0, done_exp = 0;
   logic [1:0]    hold_exp = 2'b00;

   always @(negedge clk) begin
      logic [EW-1:0]      e;
      logic [NUM_ROW-1:0] exp_row;
      int                 d;
      int                 kk;
      if (rst) begin
         exp_q.delete();
         stamp_q.delete();
         flush_pend = 0; flush_next = 0; done_exp = 0; prev_adv = 1; hold_exp = 2'b00;
         pop_n = 0; fire_n = 0; row15_n = 0; beat_idx = 1 << 30;
      end else begin
         if (acc_start) begin
            beat_idx = 0; pop_n = 0; fire_n = 0; row15_n = 0;
         end
         if (prev_adv) begin
            chk("bank_vld", bank_vld, exp_q.size() != 0);
            if (bank_vld && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               pop_n++;
               chk("bank_beat", {bank_acc_reset, bank_act, bank_wgt}, e[EW-2:0]);
               if (e[EW-1]) stamp_q.push_back(adv_n);
               if (pop_n == job_k * job_tiles) flush_pend = 1;
               hold_exp = {1'b1, e[EW-2]};
            end else if (!bank_vld) begin
               chk("bank_acc_reset", bank_acc_reset, flush_next);
               if (flush_next) stamp_q.push_back(adv_n);
               hold_exp = {1'b0, flush_next};
            end
            flush_next = 0;
         end else begin
            chk("bank_hold", {bank_vld, bank_acc_reset}, hold_exp);
         end
         if (flush_pend && fm_rdy) begin
            flush_next = 1;
            flush_pend = 0;
         end
         exp_row = '0;
         if (fm_rdy) begin
            foreach (stamp_q[i]) begin
               d = adv_n - stamp_q[i];
               if (d >= DRAIN_LAT && d < DRAIN_LAT + NUM_ROW) exp_row[d-DRAIN_LAT] = 1'b1;
            end
         end
         chk("fm_row_vld", fm_row_vld, exp_row);
         chk("done", done, done_exp);
         if (exp_row[NUM_ROW-1]) row15_n++;
         done_exp = (exp_row[NUM_ROW-1] && row15_n == job_tiles) || (acc_start && zero_start);
         chk("rdy_pair", wgt_rdy, act_rdy);
         chk("rdy_legal", act_rdy & ~(act_vld & wgt_vld & fm_rdy), 1'b0);
         if (act_rdy && act_vld && wgt_vld) begin
            kk = (job_k == 0) ? 1 : job_k;
            fire_n++;
            chk("extra_fire", beat_idx >= job_k * job_tiles, 1'b0);
            exp_q.push_back({(beat_idx % kk == 0) && (beat_idx >= kk), beat_idx % kk == 0,
                             act_data, wgt_data});
            beat_idx++;
         end
         if (fm_rdy) adv_n++;
         while (stamp_q.size() > 0 && adv_n - stamp_q[0] >= DRAIN_LAT + NUM_ROW)
            void'(stamp_q.pop_front());
         prev_adv = fm_rdy;
      end
   end

   // driver tasks
   function automatic logic [AW-1:0] rnd_act();
      logic [AW-1:0] r;
      for (int i = 0; i < AW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [WW-1:0] rnd_wgt();
      logic [WW-1:0] r;
      for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      start      = 1'b0;
      acc_start  = 1'b0;
      zero_start = 1'b0;
      act_data   = rnd_act();
      wgt_data   = rnd_wgt();
   endtask

   task automatic do_start(input int k, input int tiles, input logic [QNT_WIDTH-1:0] sc,
                           input logic [ACT_WIDTH-1:0] sh, input logic [ACT_WIDTH-1:0] zp,
                           input bit accepted, output int c);
      step();
      start        = 1'b1;
      cfg_num_k    = CNT_WIDTH'(k);
      cfg_num_tile = CNT_WIDTH'(tiles);
      cfg_scale    = sc;
      cfg_shift    = sh;
      cfg_zp       = zp;
      c            = cyc;
      if (accepted) begin
         job_k      = k;
         job_tiles  = tiles;
         acc_start  = 1'b1;
         zero_start = (k == 0 || tiles == 0);
      end
   endtask

   // Runs until done, applying the act_vld toggle and two 5-cycle fm_rdy stalls (offsets from start).
   task automatic wait_done(input string tag, input int start_c, input int exp_len,
                            input bit tog, input int s1, input int s2);
      int  n = 0;
      bit  seen = 0;
      int  dc = 0;
      int  rel;
      while (!seen && n < 400) begin
         step();
         n++;
         rel     = cyc - start_c;
         act_vld = tog ? (rel % 2 == 1) : 1'b1;
         fm_rdy  = !((s1 >= 0 && rel >= s1 && rel < s1 + 5) || (s2 >= 0 && rel >= s2 && rel < s2 + 5));
         if (done) begin
            seen = 1;
            dc   = cyc;
         end
      end
      chk({tag, "_len"}, seen ? dc - start_c : -1, exp_len);
      fm_rdy  = 1'b1;
      act_vld = 1'b1;
   endtask

   initial begin
      int c, c2;
      wgt_vld = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_bank_vld", bank_vld, 1'b0);
      chk("rst_acc", bank_acc_reset, 1'b0);
      chk("rst_rows", fm_row_vld, '0);
      chk("rst_quant", {quant_scale, quant_shift, quant_zero_point}, '0);
      chk("rst_bank_data", {bank_act, bank_wgt}, '0);
      chk("bank_rdy_hi", bank_rdy, 1'b1);
      fm_rdy = 1'b0;
      #1;
      chk("bank_rdy_lo", bank_rdy, 1'b0);
      fm_rdy = 1'b1;

      // basic job
      act_vld = 1'b1;
      do_start(4, 2, 20'h12345, 8'h07, 8'h80, 1, c);
      chk("basic_busy_c", busy, 1'b0);
      step();
      chk("basic_busy_c1", busy, 1'b1);
      wait_done("basic", c, 44, 0, -1, -1);
      chk("basic_fires", fire_n, 8);
      chk("basic_quant", {quant_scale, quant_shift, quant_zero_point}, {20'h12345, 8'h07, 8'h80});
      step();
      chk("basic_idle", busy, 1'b0);

      // act_vld toggling
      act_vld = 1'b0;
      do_start(3, 1, 20'h00abc, 8'h03, 8'h11, 1, c);
      wait_done("toggle", c, 41, 1, -1, -1);
      chk("toggle_fires", fire_n, 3);

      // fm_rdy stalls mid-FEED and mid-DRAIN
      do_start(4, 2, 20'h0f0f0, 8'h05, 8'h22, 1, c);
      wait_done("stall", c, 54, 0, 4, 30);
      chk("stall_fires", fire_n, 8);

      // zero-sized jobs
      act_vld = 1'b1;
      do_start(0, 5, 20'h00001, 8'h01, 8'h01, 1, c);
      step();
      chk("zk_done", done, 1'b1);
      chk("zk_busy", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("zk_busy_hold", busy, 1'b0);
         chk("zk_act_rdy", act_rdy, 1'b0);
      end
      do_start(3, 0, 20'h00002, 8'h02, 8'h02, 1, c);
      step();
      chk("zt_done", done, 1'b1);
      chk("zt_quant", quant_scale, 20'h00002);

      // start while busy is ignored
      do_start(4, 1, 20'hbeef1, 8'h09, 8'h33, 1, c);
      step();
      step();
      do_start(7, 3, 20'h55555, 8'h0a, 8'h44, 0, c2);
      chk("busy_at_restart", busy, 1'b1);
      wait_done("ignored_start", c, 40, 0, -1, -1);
      chk("ignored_fires", fire_n, 4);
      chk("ignored_quant", {quant_scale, quant_shift, quant_zero_point}, {20'hbeef1, 8'h09, 8'h33});

      // reset during DRAIN
      do_start(2, 1, 20'h7777a, 8'h0c, 8'h55, 1, c);
      repeat (15) step();
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_bank", {bank_vld, bank_acc_reset, act_rdy, wgt_rdy}, 4'b0000);
      chk("abort_rows", fm_row_vld, '0);
      chk("abort_quant", {quant_scale, quant_shift, quant_zero_point}, '0);
      repeat (40) step();
      do_start(3, 2, 20'h0c0de, 8'h0e, 8'h66, 1, c);
      wait_done("after_rst", c, 42, 0, -1, -1);
      chk("after_rst_fires", fire_n, 6);
      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sya_bank_ctrl.md
# sya_bank_ctrl

Sequencer for one systolic PE bank. It latches a job configuration and streams K activation/weight beats per output tile from the act and wgt buffers into the bank. It marks tile boundaries with the accumulator-reset flag, flushes the final tile, and generates per-row valid strobes for the bank's quantized feature-map outputs. It sits between the global buffers and the bank, and owns the bank's vld/rdy/acc-reset and quant-config inputs.

## Interface
- NUM_ROW, 16, bank rows (activation lanes)
- NUM_COL, 16, bank columns (weight lanes)
- ACT_WIDTH, 8, activation width
- WGT_WIDTH, 8, weight width
- QNT_WIDTH, 20, quant scale width
- CNT_WIDTH, 16, width of K and tile counters
- DRAIN_LAT, 18, advancing cycles from a closing acc-reset beat at the bank input to row 0's out_fm being valid
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- start  in  1  job start pulse; honoured only in IDLE
- cfg_num_k  in  CNT_WIDTH  beats per tile
- cfg_num_tile  in  CNT_WIDTH  tiles per job
- cfg_scale / cfg_shift / cfg_zp  in  QNT_WIDTH / ACT_WIDTH / ACT_WIDTH  quant config
- act_vld, act_rdy  in/out  1  act buffer handshake
- act_data  in  ACT_WIDTH*NUM_ROW  activation beat
- wgt_vld, wgt_rdy  in/out  1  wgt buffer handshake
- wgt_data  in  WGT_WIDTH*NUM_COL  weight beat
- fm_rdy  in  1  fm sink ready; global advance enable
- bank_vld, bank_rdy, bank_acc_reset  out  1  bank control
- bank_act / bank_wgt  out  ACT_WIDTH*NUM_ROW / WGT_WIDTH*NUM_COL  registered beat data
- quant_scale / quant_shift / quant_zero_point  out  config widths  latched config
- fm_row_vld  out  NUM_ROW  bit r: bank out_fm row r holds a valid result this cycle
- busy, done  out  1  job active; one-cycle completion pulse

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE: start=1 latches the config and quant registers, clears counters, and goes to FEED.
  - If cfg_num_k==0 or cfg_num_tile==0, it pulses done next cycle and stays IDLE with no beats issued.
- adv = fm_rdy. bank_rdy = fm_rdy combinationally. All state, counters, and the drain pipe hold when adv=0.
- FEED:
  - fire = act_vld & wgt_vld & adv. act_rdy = wgt_rdy = fire.
  - On fire: bank_vld<=1, bank_act/bank_wgt<=inputs, bank_acc_reset<=(k_cnt==0), and k_cnt increments.
  - At k_cnt==num_k-1, k_cnt wraps to 0 and tile_cnt increments.
  - After the last beat of the last tile, go to FLUSH.
  - On adv without fire: bank_vld<=0 and bank_acc_reset<=0 (bubble).
- FLUSH: on adv, bank_vld<=0, bank_acc_reset<=1, then go to DRAIN.
- Closing beat: an acc-reset beat with tile_cnt>0, or the flush beat. Each closing beat inserts a 1 into a DRAIN_LAT+NUM_ROW-1 deep shift pipe that advances on adv.
  - fm_row_vld[r] = pipe tap DRAIN_LAT-1+r, gated by adv.
- out_cnt increments on each fm_row_vld[NUM_ROW-1].
- DRAIN: when out_cnt reaches num_tile, pulse done and go to IDLE.
- busy=1 in FEED, FLUSH, and DRAIN.
- start outside IDLE is ignored.
- Config inputs are sampled only on an accepted start. Quant outputs hold until the next accepted start.

## Timing
- Reset values: all outputs 0 (bank_rdy follows fm_rdy), state IDLE, counters 0, pipe cleared.
- Reset mid-job aborts immediately. No done pulse. A held buffer beat is not consumed.
- start accepted at cycle c: busy=1 from c+1. The first possible fire is at c+1.
- Input-to-bank latency is 1 cycle (registered).
- Row r of tile t is flagged exactly DRAIN_LAT+r advancing cycles after tile t's closing beat is registered onto bank_*.
- done is asserted the cycle after the final fm_row_vld[NUM_ROW-1].
- Stall-free job length: num_k*num_tile + 1 flush beat + DRAIN_LAT + NUM_ROW cycles, plus 1 cycle for done.
- Counters are CNT_WIDTH wide. num_k and num_tile up to 2^CNT_WIDTH-1 are legal.

## Test plan
- Basic job: num_k=4, num_tile=2, buffers always valid, fm_rdy=1.
  - bank_vld high 8 cycles from c+2 and bank_acc_reset high on beats 0 and 4.
  - Flush beat at c+10. done one cycle after the last fm_row_vld[15], 44 cycles after start.
- act_vld toggles 1/0 with num_k=3, num_tile=1.
  - Bubbles appear as bank_vld=0; exactly 3 fires, acc_reset only on the first.
  - Row timing is relative to the flush beat.
- fm_rdy low for 5 cycles mid-FEED and mid-DRAIN.
  - No fires during the stall. Pipe and counters frozen; fm_row_vld=0.
  - Outputs shift later by exactly 5 cycles each stall.
- num_k=0 start: done at c+1, busy stays 0, and act_rdy/wgt_rdy never assert.
- Start while busy (second start at FEED): ignored; quant outputs keep the first job's values.
- rst=1 during DRAIN: next cycle all outputs 0, IDLE, no done. A fresh start then completes normally.
